// File: rtl/lbus_cmd_master.sv
// Byte-stream command master: parses 'W'/'R' frames, arbitrates for the local bus, returns read data on tx.
// Define LBM_ACK_EN to make every completed write answer with a single 0x06 byte.
module lbus_cmd_master #(
  parameter int XLEN     = 32,
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] qin,
  output logic [2:0]      we,
  input  logic [XLEN-1:0] qout,
  output logic            busy
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, XFER, RWAIT, RESP} state_t;

  state_t            state, nxt;
  logic              up, is_wr;
  logic [1:0]        bcnt, wcnt;
  logic [XLEN-1:0]   addr_r, data_r, resp_r;
  logic [TW-1:0]     tcnt;
  logic              rx_fire, tx_fire, timed_out, wait_done, last_tx, in_frame;

  assign in_frame  = (state == ADDR) || (state == DATA);
  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign timed_out = (tcnt == TW'(TIMEOUT));
  assign wait_done = (wcnt == 2'(READ_LAT - 1));
  assign last_tx   = is_wr | (bcnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (rx_fire && (rx_data == 8'h57 || rx_data == 8'h52)) nxt = ADDR;
      ADDR:  if (rx_fire) begin
               if (bcnt == 2'd3) nxt = is_wr ? DATA : REQ;
             end else if (timed_out) nxt = IDLE;
      DATA:  if (rx_fire) begin
               if (bcnt == 2'd3) nxt = REQ;
             end else if (timed_out) nxt = IDLE;
      REQ:   if (bus_gnt) nxt = XFER;
`ifdef LBM_ACK_EN
      XFER:  nxt = is_wr ? RESP : RWAIT;
`else
      XFER:  nxt = is_wr ? IDLE : RWAIT;
`endif
      RWAIT: if (wait_done) nxt = RESP;
      RESP:  if (tx_fire && last_tx) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up     <= 1'b0;
      is_wr  <= 1'b0;
      bcnt   <= '0;
      wcnt   <= '0;
      addr_r <= '0;
      data_r <= '0;
      resp_r <= '0;
      tcnt   <= '0;
    end else begin
      up <= 1'b1;
      // Idle gap counter only runs while a frame is partially collected.
      if (rx_fire || !in_frame) tcnt <= '0;
      else if (!timed_out)      tcnt <= tcnt + 1'b1;
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (rx_fire && (rx_data == 8'h57 || rx_data == 8'h52)) is_wr <= (rx_data == 8'h57);
        end
        ADDR: if (rx_fire) begin
          bcnt   <= bcnt + 1'b1;
          addr_r <= {rx_data, addr_r[XLEN-1:8]};
        end
        DATA: if (rx_fire) begin
          bcnt   <= bcnt + 1'b1;
          data_r <= {rx_data, data_r[XLEN-1:8]};
        end
        XFER: begin
          wcnt <= '0;
          bcnt <= '0;
          if (is_wr) resp_r <= XLEN'(8'h06);
        end
        RWAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wait_done) resp_r <= qout;
        end
        RESP: if (tx_fire) bcnt <= bcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Bus outputs are zero outside the transfer window so they can be OR-merged with the CPU bus.
  always_comb begin
    tx_data = 8'h00;
    if (state == RESP) begin
      case (bcnt)
        2'd0: tx_data = resp_r[7:0];
        2'd1: tx_data = resp_r[15:8];
        2'd2: tx_data = resp_r[23:16];
        default: tx_data = resp_r[31:24];
      endcase
    end
  end

  assign tx_valid = (state == RESP);
  assign rx_ready = up & ((state == IDLE) || in_frame);
  assign busy     = (state != IDLE);
  assign bus_req  = (state == REQ) || (state == XFER) || (state == RWAIT);
  assign addr     = ((state == XFER) || (state == RWAIT)) ? addr_r : '0;
  assign qin      = ((state == XFER) && is_wr) ? data_r : '0;
  assign we       = ((state == XFER) && is_wr) ? 3'b100 : 3'b000;
endmodule

// File: tb/tb_lbus_cmd_master.sv
// Scoreboard bench for lbus_cmd_master: directed frames, expected bus cycles and tx bytes queued, monitor compares.
module tb_lbus_cmd_master;
  localparam int TMO = 40;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] qin;
    logic [2:0]  we;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [31:0] addr, qin, qout;
  logic [2:0]  we;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  bit   bp = 0;
  bus_t exp_bus[$];
  logic [7:0] exp_tx[$];

  lbus_cmd_master #(.XLEN(32), .READ_LAT(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .addr(addr), .qin(qin), .we(we), .qout(qout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    tx_ready = bp ? ~tx_ready : 1'b1;
  end

  // Memory model: read data is valid only in the cycle right after the address cycle.
  function automatic logic [31:0] rdval(input logic [31:0] a);
    case (a)
      32'h10000004: rdval = 32'h12345678;
      32'h10000008: rdval = 32'hA1B2C3D4;
      default:      rdval = 32'hBAD0BAD0;
    endcase
  endfunction

  logic addr_prev = 1'b0;
  always @(posedge clk) begin
    qout      <= (addr != 0 && !addr_prev) ? rdval(addr) : 32'hBAD0BAD0;
    addr_prev <= (addr != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: bus cycles detected as the rising edge of any nonzero bus output.
  bit        prev_act = 0, prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    bit act;
    bus_t e;
    if (!rst_n) begin
      prev_act   = 0;
      prev_stall = 0;
    end else begin
      act = (addr != 0) || (we != 0) || (qin != 0);
      if (act && !prev_act) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexp: got addr=0x%08h we=%0b want no bus cycle", addr, we);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_addr", addr, e.addr);
          chk("bus_qin", qin, e.qin);
          chk("bus_we", 32'(we), 32'(e.we));
        end
      end
      prev_act = act;
      if (prev_stall) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexp: got 0x%02h want no byte", tx_data);
        end else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL rx_accept: got rx_ready=0 want 1 within 200 cycles");
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send(op);
    for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
    if (op == 8'h57) for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL drain: got %0d tx / %0d bus pending want 0", exp_tx.size(), exp_bus.size());
    end
  endtask

  task automatic ack_expect();
`ifdef LBM_ACK_EN
    exp_tx.push_back(8'h06);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_bus_req"}, 32'(bus_req), 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_qin"}, qin, 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first-clock rx_ready.
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    #1 chk("rx_ready_release", 32'(rx_ready), 0);
    @(posedge clk);
    #1 chk("rx_ready_up", 32'(rx_ready), 1);

    // Write with grant already high: XFER two cycles after the last byte.
    exp_bus.push_back('{addr: 32'h20000000, qin: 32'hDEADBEEF, we: 3'b100});
    ack_expect();
    send_frame(8'h57, 32'h20000000, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_req_n1", 32'(bus_req), 1);
    chk("wr_we_n1", 32'(we), 0);
    @(negedge clk);
    chk("wr_we_n2", 32'(we), 32'b100);
    chk("wr_addr_n2", addr, 32'h20000000);
    chk("wr_qin_n2", qin, 32'hDEADBEEF);
    drain();

    // Read: response byte order and latency.
    exp_bus.push_back('{addr: 32'h10000004, qin: 32'h0, we: 3'b000});
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    send_frame(8'h52, 32'h10000004, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_xfer_addr", addr, 32'h10000004);
    chk("rd_xfer_txv", 32'(tx_valid), 0);
    @(negedge clk);
    chk("rd_rwait_addr", addr, 32'h10000004);
    chk("rd_rwait_txv", 32'(tx_valid), 0);
    @(negedge clk);
    chk("rd_resp_txv", 32'(tx_valid), 1);
    chk("rd_resp_addr", addr, 0);
    drain();

    // Delayed grant: 20 cycles waiting in REQ.
    bus_gnt = 1'b0;
    exp_bus.push_back('{addr: 32'h30000010, qin: 32'h11223344, we: 3'b100});
    ack_expect();
    send_frame(8'h57, 32'h30000010, 32'h11223344);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("dg_req", 32'(bus_req), 1);
      chk("dg_addr", addr, 0);
      chk("dg_we", 32'(we), 0);
      chk("dg_rx_ready", 32'(rx_ready), 0);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    chk("dg_xfer_we", 32'(we), 32'b100);
    chk("dg_xfer_addr", addr, 32'h30000010);
    drain();

    // Garbage byte, then a stalled partial frame that must time out.
    send(8'h41);
    @(negedge clk);
    chk("garbage_busy", 32'(busy), 0);
    send(8'h57);
    send(8'h00);
    repeat (TMO - 10) @(negedge clk);
    chk("tmo_not_yet", 32'(busy), 1);
    repeat (15) @(negedge clk);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_rx_ready", 32'(rx_ready), 1);
    exp_bus.push_back('{addr: 32'h20000040, qin: 32'hCAFEF00D, we: 3'b100});
    ack_expect();
    send_frame(8'h57, 32'h20000040, 32'hCAFEF00D);
    drain();

    // Read with tx backpressure.
    bp = 1;
    exp_bus.push_back('{addr: 32'h10000008, qin: 32'h0, we: 3'b000});
    exp_tx.push_back(8'hD4); exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'hB2); exp_tx.push_back(8'hA1);
    send_frame(8'h52, 32'h10000008, 32'h0);
    drain();
    bp = 0;
    repeat (4) @(negedge clk);

    // Reset during RWAIT: outputs clear at once, no response afterwards.
    exp_bus.push_back('{addr: 32'h1000000C, qin: 32'h0, we: 3'b000});
    send_frame(8'h52, 32'h1000000C, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("mid_rwait_req", 32'(bus_req), 1);
    rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_rx_ready_release", 32'(rx_ready), 0);
    @(posedge clk);
    #1 chk("rst2_rx_ready_up", 32'(rx_ready), 1);
    repeat (20) @(negedge clk);
    chk("rst2_busy", 32'(busy), 0);
    chk("final_tx_pending", exp_tx.size(), 0);
    chk("final_bus_pending", exp_bus.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
